// File: rtl/tb_test_ctrl.sv
// Test-sequencing controller for the tinyriscv simulation top: loads the
// firmware byte stream into ROM, holds/releases the core reset, then watches
// the x26/x27 signature under a cycle watchdog and latches a sticky verdict.
module tb_test_ctrl #(
  parameter int unsigned ROM_AW   = 12,
  parameter int unsigned RST_HOLD = 16,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [7:0]        ld_data_i,
  input  logic              ld_last_i,
  output logic              rom_we_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic [31:0]       rom_wdata_o,
  output logic              core_rst_o,
  input  logic [31:0]       x26_i,
  input  logic [31:0]       x27_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic              load_err_o,
  output logic [31:0]       cycle_cnt_o
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FLUSH,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         asm_q, asm_d;
  logic [ROM_AW-1:0]   ptr_q, ptr_d;
  logic                full_q, full_d;
  logic [CNT_W-1:0]    hold_q, hold_d;

  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ROM_AW-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                core_rst_q, core_rst_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                to_q, to_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [31:0]         word_c;
  logic                accept_c;

  // Next-state and registered-output logic for the whole test sequence.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    asm_d      = asm_q;
    ptr_d      = ptr_q;
    full_d     = full_q;
    hold_d     = hold_q;
    ready_d    = ready_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    pass_d     = pass_q;
    to_d       = to_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    accept_c   = ld_valid_i & ready_q;

    // Current byte merged into its lane; lanes above it are still zero.
    word_c = {8'h00, asm_q};
    case (lane_q)
      2'd0:    word_c[7:0]   = ld_data_i;
      2'd1:    word_c[15:8]  = ld_data_i;
      2'd2:    word_c[23:16] = ld_data_i;
      default: word_c[31:24] = ld_data_i;
    endcase

    case (state_q)
      S_LOAD: begin
        ready_d = 1'b1;
        if (accept_c) begin
          if ((lane_q == 2'd3) || ld_last_i) begin
            lane_d = 2'd0;
            asm_d  = 24'h0;
            if (full_q) begin
              err_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              addr_d  = ptr_q;
              wdata_d = word_c;
              ptr_d   = ptr_q + ROM_AW'(1);
              if (ptr_q == {ROM_AW{1'b1}}) full_d = 1'b1;
            end
            if (ld_last_i) begin
              ready_d = 1'b0;
              state_d = S_FLUSH;
            end
          end else begin
            asm_d  = word_c[23:0];
            lane_d = lane_q + 2'd1;
          end
        end
      end
      S_FLUSH: begin
        ready_d = 1'b0;
        hold_d  = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          core_rst_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_RUN;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (x26_i == 32'd1) begin
          done_d  = 1'b1;
          pass_d  = (x27_i == 32'd1);
          to_d    = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          done_d  = 1'b1;
          pass_d  = 1'b0;
          to_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // State and output registers; reset discards any partial word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_LOAD;
      lane_q     <= 2'd0;
      asm_q      <= 24'h0;
      ptr_q      <= '0;
      full_q     <= 1'b0;
      hold_q     <= '0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      to_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      ptr_q      <= ptr_d;
      full_q     <= full_d;
      hold_q     <= hold_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      to_q       <= to_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ld_ready_o  = ready_q;
  assign rom_we_o    = we_q;
  assign rom_addr_o  = addr_q;
  assign rom_wdata_o = wdata_q;
  assign core_rst_o  = core_rst_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = to_q;
  assign load_err_o  = err_q;
  assign cycle_cnt_o = cnt_q;

endmodule
